// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, up to two outstanding imem requests, 2-entry
// instruction queue toward decode, redirect flush with stale-response dropping.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY = '{pc: '0, word: NOP};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      inflight_q, inflight_d;
  logic [1:0]      drop_q, drop_d;
  fetch_entry_t    fq0_q, fq0_d, fq1_q, fq1_d;
  logic            fv0_q, fv0_d, fv1_q, fv1_d;
  logic [XLEN-1:0] aq0_q, aq0_d, aq1_q, aq1_d;
  logic [1:0]      aq_cnt;
  logic [1:0]      fifo_cnt;
  logic [2:0]      credits_used;
  logic            req_fire, resp_fire, deq;
  logic            redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Queue is kept contiguous from slot 0, so occupancy follows from the valids.
  assign fifo_cnt     = {fv1_q, fv0_q & ~fv1_q};
  assign deq          = fv0_q & inst_ready;
  assign credits_used = 3'(inflight_q) + 3'(fifo_cnt) - 3'(deq);

  assign imem_req_valid = rst_n & ~redirect_valid & (credits_used < 3'd2);
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_fire      = imem_resp_valid;

  assign inst_valid = fv0_q;
  assign inst       = fq0_q.word;
  assign inst_pc    = fq0_q.pc;

  // Next-state: address queue, PC, drop accounting and instruction queue.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + 2'(req_fire) - 2'(resp_fire);
    drop_d     = drop_q;
    fq0_d      = fq0_q;
    fq1_d      = fq1_q;
    fv0_d      = fv0_q;
    fv1_d      = fv1_q;
    aq0_d      = aq0_q;
    aq1_d      = aq1_q;
    aq_cnt     = inflight_q - 2'(resp_fire);

    if (resp_fire) begin
      aq0_d = aq1_q;
      aq1_d = '0;
    end
    if (req_fire) begin
      if (aq_cnt == 2'd0) aq0_d = pc_q;
      else                aq1_d = pc_q;
      pc_d = pc_q + 32'd4;
    end

    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = inflight_d;
      fq0_d  = EMPTY;
      fq1_d  = EMPTY;
      fv0_d  = 1'b0;
      fv1_d  = 1'b0;
    end else begin
      if (resp_fire && drop_q != 2'd0) drop_d = drop_q - 2'd1;
      if (deq) begin
        fq0_d = fq1_q;
        fv0_d = fv1_q;
        fq1_d = EMPTY;
        fv1_d = 1'b0;
      end
      // Credit accounting guarantees a free slot for every non-dropped response.
      if (resp_fire && drop_q == 2'd0) begin
        if (!fv0_d) begin
          fq0_d = '{pc: aq0_q, word: imem_resp_data};
          fv0_d = 1'b1;
        end else begin
          fq1_d = '{pc: aq0_q, word: imem_resp_data};
          fv1_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      fq0_q      <= EMPTY;
      fq1_q      <= EMPTY;
      fv0_q      <= 1'b0;
      fv1_q      <= 1'b0;
      aq0_q      <= '0;
      aq1_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fq0_q      <= fq0_d;
      fq1_q      <= fq1_d;
      fv0_q      <= fv0_d;
      fv1_q      <= fv1_d;
      aq0_q      <= aq0_d;
      aq1_q      <= aq1_d;
    end
  end

endmodule
